// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline sequencing controller for the 5-stage RV32I core. It works
//   alongside the forwarding unit and covers what forwarding cannot:
//   load-use hazards, data-memory wait freezes (with timeout detection) and
//   the IF/ID + ID/EX flush for a taken branch or jump resolved in EX.
//
// Parameters
//   MEM_TIMEOUT  freeze cycles after which mem_timeout asserts (1..2^TO_W-1)
//   TO_W         width of the freeze-cycle counter
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   inst_id         instruction held in IF/ID (decode stage)
//   inst_ex         instruction held in ID/EX (execute stage)
//   branch_taken    EX resolved a taken branch/JAL/JALR this cycle
//   mem_busy        data memory not ready; the whole pipeline must hold
//   pc_en           PC register load enable
//   if_id_en        IF/ID register enable
//   if_id_flush     IF/ID loads a NOP
//   id_ex_flush     ID/EX loads a bubble
//   ex_mem_en       EX/MEM and MEM/WB enable
//   load_use_stall  status: load-use stall active this cycle
//   mem_timeout     sticky: a freeze exceeded MEM_TIMEOUT cycles
//   stall_cnt       load-use stall cycles (performance counter build only)
//   flush_cnt       branch-flush events (performance counter build only)
//
// Build option
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt/flush_cnt are real saturating
//                       counters; otherwise they are tied to zero.
//
// State  | meaning
// -------+-----------------------------------------------------------------
// RUN    | pipeline flowing; stall/flush decided per cycle
// FREEZE | data memory busy; everything held, taken branches remembered

module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_id,
    input  logic [31:0]      inst_ex,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             load_use_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            flush_pend_q, flush_pend_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    // ---------------------------------------------------------------
    // Load-use decode
    // ---------------------------------------------------------------
    logic [6:0] opc_id;
    logic [4:0] rd_ex;
    logic       ld_ex;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;

    assign opc_id = inst_id[6:0];
    assign rd_ex  = inst_ex[11:7];
    // A load into x0 produces nothing to wait for.
    assign ld_ex  = (inst_ex[6:0] == 7'b0000011) && (rd_ex != 5'd0);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc_id)
            7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end // R-type
            7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end // store
            7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end // branch
            7'b0010011: use_rs1 = 1'b1;                           // OP-IMM
            7'b0000011: use_rs1 = 1'b1;                           // load
            7'b1100111: use_rs1 = 1'b1;                           // JALR
            default:    ;                                         // U/J/unknown
        endcase
    end

    assign hazard = ld_ex &&
                    ((use_rs1 && (inst_id[19:15] == rd_ex)) ||
                     (use_rs2 && (inst_id[24:20] == rd_ex)));

    // Bits of the instruction words that play no part in hazard decode.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_id[31:25], inst_id[14:7], inst_ex[31:12]};

    // ---------------------------------------------------------------
    // Next-state and control outputs
    // ---------------------------------------------------------------
    logic do_freeze;
    logic do_flush;
    logic do_stall;

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        do_freeze    = 1'b0;
        do_flush     = 1'b0;
        do_stall     = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    do_freeze    = 1'b1;
                    flush_pend_d = branch_taken;
                    state_d      = FREEZE;
                end else if (branch_taken) begin
                    do_flush = 1'b1;
                end else if (hazard) begin
                    do_stall = 1'b1;
                end
            end
            FREEZE: begin
                if (mem_busy) begin
                    do_freeze    = 1'b1;
                    flush_pend_d = flush_pend_q | branch_taken;
                    if (wait_cnt_q != {TO_W{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // Judge on the updated count so the flag rises at the end
                    // of the MEM_TIMEOUT-th busy cycle of the freeze.
                    if (wait_cnt_d >= TO_LIM) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d   = '0;
                    flush_pend_d = 1'b0;
                    state_d      = RUN;
                    if (flush_pend_q || branch_taken) begin
                        do_flush = 1'b1;
                    end else if (hazard) begin
                        do_stall = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        ex_mem_en      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        load_use_stall = 1'b0;

        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (do_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (do_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (do_stall) begin
            // The bubble pushes the load on to MEM, so this lasts one cycle.
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            id_ex_flush    = 1'b1;
            load_use_stall = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    // ---------------------------------------------------------------
    // Performance counters
    // ---------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_use_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (do_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
